// File: rtl/trace_buffer.sv
// trace_buffer: circular capture buffer fed by the data packer.
//
// While tracing=1, every valid packed vector is written at wr_ptr. When the
// buffer is full, the oldest entry is overwritten, so the buffer always holds
// the most recent TB_SIZE vectors. While tracing=0, the host pops entries
// oldest-first. Each accepted rd_req returns data one cycle later on rd_data,
// marked by rd_valid.
//
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   tracing      1 = capture phase, 0 = drain phase
//   valid_in     packer valid_out
//   vector_in    packer vector_out, N lanes of DATA_WIDTH bits
//   rd_req       pop request, honoured only in the drain phase
//   rd_data      popped vector (holds its value between pops)
//   rd_valid     single-cycle pulse for each accepted pop
//   count        number of stored entries
//   empty/full   decoded from count
//   overflow     sticky flag: an entry was overwritten since the last time
//                the buffer was empty
//
// state   | meaning
// --------+----------------------------------------------------------
// CAPTURE | tracing was 1 last cycle; reads are blocked
// DRAIN   | tracing was 0 last cycle; reads allowed while tracing=0
module trace_buffer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         vector_in [N-1:0],
  input  logic                          rd_req,
  output logic [DATA_WIDTH-1:0]         rd_data [N-1:0],
  output logic                          rd_valid,
  output logic [$clog2(TB_SIZE+1)-1:0]  count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow
);

  localparam int PW = $clog2(TB_SIZE);
  localparam int CW = $clog2(TB_SIZE+1);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH = CW'(TB_SIZE);

  typedef enum logic {CAPTURE = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            rd_valid_q, rd_valid_d;
  logic [VW-1:0]   rd_data_q, rd_data_d;
  logic [VW-1:0]   mem_q [TB_SIZE];
  logic [VW-1:0]   vec_in_flat;
  logic            wr_en;
  logic            rd_en;

  // Lanes are stored flattened so one memory word holds one whole vector.
  always_comb begin
    vec_in_flat = '0;
    for (int i = 0; i < N; i++) begin
      vec_in_flat[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_data[i] = rd_data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    state_d    = tracing ? CAPTURE : DRAIN;
    // Reading needs the registered state to already be DRAIN, so the cycle
    // in which tracing falls neither writes nor reads.
    wr_en      = tracing && valid_in;
    rd_en      = (state_q == DRAIN) && !tracing && rd_req && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (full) begin
        // The oldest entry is being overwritten, so the read side skips it.
        rd_ptr_d   = rd_ptr_q + PW'(1);
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end

    if (rd_en) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PW'(1);
      count_d    = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= vec_in_flat;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int SZ = 4;
  localparam int CW = $clog2(SZ+1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          tracing;
  logic          valid_in;
  logic [DW-1:0] vector_in [N-1:0];
  logic          rd_req;
  logic [DW-1:0] rd_data [N-1:0];
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  logic [N*DW-1:0] rd_flat;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: stored vectors (by k), in-flight expected pops, prior tracing.
  int   model_q[$];
  int   exp_q[$];
  logic m_prev_tr;

  trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(SZ)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tracing   (tracing),
    .valid_in  (valid_in),
    .vector_in (vector_in),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) rd_flat[i*DW +: DW] = rd_data[i];
  end

  function automatic logic [N*DW-1:0] vec_of(input int k);
    logic [DW-1:0] lane;
    lane = DW'(k);
    return {N{lane}};
  endfunction

  // Scoreboard consumer: every rd_valid pulse must match the oldest expected pop.
  always @(negedge clk) begin
    if (resetn) begin
      if (rd_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_valid: rd_valid=1 rd_data=%h, expected no pop", rd_flat);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (rd_flat !== vec_of(e)) begin
            tests_failed++;
            $display("FAIL sb_data: rd_data=%h expected=%h", rd_flat, vec_of(e));
          end
        end
      end else if (exp_q.size() != 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_missing_valid: rd_valid=0, expected pop of vector %0d", exp_q[0]);
        exp_q.delete();
      end
    end
  end

  // Drive one clock's worth of inputs, advance the model, return at posedge+1.
  task automatic cyc(input logic tr, input logic vin, input int k, input logic req);
    logic do_rd;
    int   popped;
    tracing  = tr;
    valid_in = vin;
    rd_req   = req;
    for (int i = 0; i < N; i++) vector_in[i] = DW'(k);
    do_rd  = !m_prev_tr && !tr && req && (model_q.size() > 0);
    popped = 0;
    if (tr && vin) begin
      if (model_q.size() == SZ) void'(model_q.pop_front());
      model_q.push_back(k);
    end
    if (do_rd) popped = model_q.pop_front();
    m_prev_tr = tr;
    @(posedge clk);
    if (do_rd) exp_q.push_back(popped);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    tracing = 1'b0; valid_in = 1'b0; rd_req = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_prev_tr = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tracing = 1'b0; valid_in = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < N; i++) vector_in[i] = '0;
    m_prev_tr = 1'b1;
    #2;
    tests_run++;
    if ({rd_valid, count, empty, full, overflow} !== {1'b0, CW'(0), 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_flags: rd_valid=%b count=%0d empty=%b full=%b overflow=%b, expected 0 0 1 0 0",
               rd_valid, count, empty, full, overflow);
    end
    tests_run++;
    if (rd_flat !== '0) begin
      tests_failed++;
      $display("FAIL reset_rd_data: rd_data=%h expected all zero", rd_flat);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b1, k, 1'b0);
    tests_run++;
    if (count !== CW'(3)) begin
      tests_failed++;
      $display("FAIL basic_count_after_write: count=%0d expected 3", count);
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      tests_run++;
      if (count !== CW'(2 - r)) begin
        tests_failed++;
        $display("FAIL basic_count_step: count=%0d expected %0d", count, 2 - r);
      end
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
    tests_run++;
    if ({empty, overflow} !== 2'b10) begin
      tests_failed++;
      $display("FAIL basic_end_flags: empty=%b overflow=%b expected 1 0", empty, overflow);
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b1, k, 1'b0);
      if (k == 4) begin
        tests_run++;
        if ({full, overflow} !== 2'b10) begin
          tests_failed++;
          $display("FAIL ovf_after_4: full=%b overflow=%b expected 1 0", full, overflow);
        end
      end
      if (k == 5) begin
        tests_run++;
        if ({full, overflow, count} !== {1'b1, 1'b1, CW'(4)}) begin
          tests_failed++;
          $display("FAIL ovf_after_5: full=%b overflow=%b count=%0d expected 1 1 4", full, overflow, count);
        end
      end
    end
    tests_run++;
    if (count !== CW'(4)) begin
      tests_failed++;
      $display("FAIL ovf_count: count=%0d expected 4", count);
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      if (r == 2) begin
        tests_run++;
        if (overflow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovf_sticky: overflow=%b expected 1 while count=%0d", overflow, count);
        end
      end
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
    tests_run++;
    if ({overflow, empty} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_clear: overflow=%b empty=%b expected 0 1", overflow, empty);
    end
  endtask

  task automatic test_empty_read();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      tests_run++;
      if ({rd_valid, count} !== {1'b0, CW'(0)} || rd_flat !== '0) begin
        tests_failed++;
        $display("FAIL empty_read: rd_valid=%b count=%0d rd_data=%h expected 0 0 zero",
                 rd_valid, count, rd_flat);
      end
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_phase_gating();
    cyc(1'b1, 1'b1, 7, 1'b1);
    tests_run++;
    if ({rd_valid, count} !== {1'b0, CW'(1)}) begin
      tests_failed++;
      $display("FAIL gate_capture: rd_valid=%b count=%0d expected 0 1", rd_valid, count);
    end
    cyc(1'b0, 1'b1, 9, 1'b0);
    cyc(1'b0, 1'b1, 9, 1'b0);
    tests_run++;
    if (count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL gate_drain_write: count=%0d expected 1", count);
    end
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0);
    tests_run++;
    if (count !== CW'(0)) begin
      tests_failed++;
      $display("FAIL gate_final_count: count=%0d expected 0", count);
    end
  endtask

  task automatic test_interleaved();
    cyc(1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    tests_run++;
    if (count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL inter_first_drain: count=%0d expected 1", count);
    end
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, 4, 1'b0);
    tests_run++;
    if (count !== CW'(3)) begin
      tests_failed++;
      $display("FAIL inter_append: count=%0d expected 3", count);
    end
    cyc(1'b0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 3; r++) cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0);
    tests_run++;
    if ({count, empty} !== {CW'(0), 1'b1}) begin
      tests_failed++;
      $display("FAIL inter_end: count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b1, k, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    #1;
    tests_run++;
    if (rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: rd_valid=%b expected 1 before reset", rd_valid);
    end
    resetn = 1'b0;
    rd_req = 1'b0;
    #1;
    tests_run++;
    if ({rd_valid, count, empty} !== {1'b0, CW'(0), 1'b1}) begin
      tests_failed++;
      $display("FAIL areset_immediate: rd_valid=%b count=%0d empty=%b expected 0 0 1",
               rd_valid, count, empty);
    end
    model_q.delete();
    exp_q.delete();
    m_prev_tr = 1'b1;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      tests_run++;
      if ({rd_valid, count} !== {1'b0, CW'(0)}) begin
        tests_failed++;
        $display("FAIL areset_after: rd_valid=%b count=%0d expected 0 0", rd_valid, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_read();
    test_phase_gating();
    test_interleaved();
    test_async_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d expected pops never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
